ps2_key_fifo: RTL and testbench
===============================

Name: ps2_key_fifo

Overview:
- Keyboard front end for the i/o space (a000_0000–bfff_ffff).
- Deserialises PS/2 frames from the keyboard and buffers scan codes in a FIFO.
- Presents the FIFO head as key_data/ready to the memory-mapped I/O bus.
- Pops one entry per CPU read strobe on io_rdn, so the bus returns {23'h0, ready, key_data}.

Parameters:
- FIFO_DEPTH, 8, number of scan-code entries; power of two, minimum 2.
- FILTER_LEN, 4, consecutive identical synchronised ps2_clk samples required to accept a level change.
- TIMEOUT_CYCLES, 10000, clk cycles without a ps2_clk falling edge mid-frame before the frame is abandoned (200 us at 50 MHz).

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous active-high reset
- ps2_clk  input  1  keyboard clock, asynchronous
- ps2_data  input  1  keyboard data, asynchronous
- io_rdn  input  1  i/o read strobe, active low, from bus decode
- key_data  output  8  FIFO head scan code; 8'h00 when empty
- ready  output  1  FIFO not empty
- overflow  output  1  sticky: a byte was dropped because the FIFO was full
- frame_err  output  1  one-cycle pulse on a discarded frame

Behaviour:
- Reset (async, rst=1): FIFO empty, pointers 0, receiver IDLE, bit count 0, timeout counter 0, filter state 1.
  - Outputs at reset: ready=0, key_data=0, overflow=0, frame_err=0.
- Input synchronisation: ps2_clk and ps2_data each pass through a 2-flop synchroniser.
- Clock filter: filtered ps2_clk changes only after FILTER_LEN consecutive equal synchronised samples.
  - Falling edge = filtered value goes 1->0.
  - All sampling of ps2_data happens on that edge, using the synchronised ps2_data.
- Frame format: 11 bits per frame.
  - Start 0, then 8 data bits LSB first, then odd parity, then stop 1.
- Receiver states:
  - IDLE: on a falling edge, if data=0 go to DATA (bit count 0). If data=1, stay in IDLE and raise no error.
  - DATA: shift each bit into bit 7 of the shift register (right shift). After the 8th bit go to PARITY.
  - PARITY: capture the parity bit, go to STOP.
  - STOP: on the falling edge, check stop=1 and that data+parity contains an odd number of ones.
    - Pass: push the byte to the FIFO in the same cycle.
    - Fail: frame_err=1 for one cycle, nothing pushed.
    - Either way, return to IDLE.
- Timeout:
  - In any state other than IDLE, the counter increments every cycle and clears on each falling edge.
  - Reaching TIMEOUT_CYCLES: frame_err pulse, return to IDLE, partial byte discarded.
- Pop:
  - Pop fires when io_rdn is low now and was high at the previous clk edge (registered io_rdn_d, reset value 1).
  - A multi-cycle low strobe pops exactly once.
  - The read itself sees the pre-pop head combinationally.
  - Pop while empty: no effect.
- FIFO:
  - Read and write pointers are log2(FIFO_DEPTH)+1 bits, wrap naturally.
  - Count = wr - rd; full when count = FIFO_DEPTH.
  - key_data = mem[rd] when not empty, else 8'h00 (combinational). ready = count != 0 (combinational).
  - Push and pop in the same cycle: both take effect and count is unchanged, including when full.
  - Push while full with no pop: byte dropped, overflow set to 1.
  - overflow clears on the next pop that occurs while no drop happens in that cycle. A drop takes priority.
- Reset mid-frame: immediate return to IDLE and FIFO cleared. The remainder of the in-flight frame is ignored until a start bit is seen after stop/idle.

Test Plan:
- Reset, then send frame 0x1C (parity 0, stop 1) -> within FILTER_LEN+3 cycles after the 11th falling edge: ready=1, key_data=8'h1C, frame_err never asserted.
- Send 0xF0 (parity 1) then 0x1C, then pulse io_rdn low 1 cycle:
  - Before the pulse, key_data=F0.
  - After the pulse, key_data=1C and ready=1.
  - Second pulse -> ready=0, key_data=00.
- Send 0x1C with parity bit 1 -> frame_err single-cycle pulse, ready stays 0. Next valid 0x1D is received correctly.
- Stop ps2_clk after 5 bits for TIMEOUT_CYCLES+10 cycles -> frame_err pulse. A following valid 0x5A frame is received as 5A.
- Push 9 frames (0x01–0x09) with DEPTH 8:
  - overflow=1, count 8, head 01.
  - Pop all 8 -> sequence 01..08.
  - overflow clears on the first pop.
  - Hold io_rdn low for 20 cycles -> only one entry popped.
- Inject 1-cycle glitches on ps2_clk (shorter than FILTER_LEN) during frame 0x33 -> received byte 0x33, no frame_err. Assert rst mid-frame -> all outputs 0 immediately.

Source files
------------

// File: rtl/ps2_key_fifo.sv
// ps2_key_fifo: PS/2 keyboard receiver with a filtered clock and a scan-code FIFO
// popped once per falling edge of the i/o read strobe.
module ps2_key_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       io_rdn,
    output logic [7:0] key_data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int FW = $clog2(FILTER_LEN + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    clk_sync_q, data_sync_q;
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    state_t        state_q, state_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [AW:0]   wr_q, wr_d, rd_q, rd_d, count;
    logic          ovf_q, ovf_d, err_q, err_d, rdn_q;
    logic [7:0]    mem_q [FIFO_DEPTH];
    logic          ps2c_s, ps2d_s, fall, push, pop, wr_en, drop, full, empty;

    assign ps2c_s = clk_sync_q[1];
    assign ps2d_s = data_sync_q[1];

    // The filtered clock only follows the synchronised input after a full run of differing samples.
    always_comb begin
        fcnt_d = '0;
        filt_d = filt_q;
        if (ps2c_s != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) filt_d = ps2c_s;
            else fcnt_d = fcnt_q + 1'b1;
        end
        fall = filt_q & ~filt_d;
    end

    always_comb begin
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        par_d   = par_q;
        tmo_d   = '0;
        push    = 1'b0;
        err_d   = 1'b0;
        if (state_q != IDLE) tmo_d = fall ? '0 : tmo_q + 1'b1;
        if (fall) begin
            case (state_q)
                IDLE: if (!ps2d_s) begin
                    state_d = DATA;
                    bit_d   = '0;
                end
                DATA: begin
                    shift_d = {ps2d_s, shift_q[7:1]};
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == 3'd7) state_d = PARITY;
                end
                PARITY: begin
                    par_d   = ps2d_s;
                    state_d = STOP;
                end
                STOP: begin
                    push    = ps2d_s & (^{shift_q, par_q});
                    err_d   = ~push;
                    state_d = IDLE;
                end
            endcase
        end else if (state_q != IDLE && tmo_d == TW'(TIMEOUT_CYCLES)) begin
            err_d   = 1'b1;
            state_d = IDLE;
            tmo_d   = '0;
        end
    end

    // A push into a full FIFO still lands when the same cycle pops, otherwise it is dropped.
    always_comb begin
        count = wr_q - rd_q;
        empty = count == '0;
        full  = count == (AW + 1)'(FIFO_DEPTH);
        pop   = ~io_rdn & rdn_q & ~empty;
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;
        wr_d  = wr_q + (AW + 1)'(wr_en);
        rd_d  = rd_q + (AW + 1)'(pop);
        ovf_d = drop | (ovf_q & ~pop);
    end

    assign key_data  = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
    assign ready     = ~empty;
    assign overflow  = ovf_q;
    assign frame_err = err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= 2'b11;
            data_sync_q <= 2'b11;
            filt_q      <= 1'b1;
            fcnt_q      <= '0;
            state_q     <= IDLE;
            bit_q       <= '0;
            shift_q     <= '0;
            par_q       <= 1'b0;
            tmo_q       <= '0;
            wr_q        <= '0;
            rd_q        <= '0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
            rdn_q       <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_q      <= filt_d;
            fcnt_q      <= fcnt_d;
            state_q     <= state_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            par_q       <= par_d;
            tmo_q       <= tmo_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
            rdn_q       <= io_rdn;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q[AW-1:0]] <= shift_q;
    end
endmodule

// File: tb/tb_ps2_key_fifo.sv
// tb_ps2_key_fifo: drives PS/2 frames and read strobes, checks outputs against a queue model.
module tb_ps2_key_fifo;
    localparam int DEPTH = 8;
    localparam int TMO   = 10000;

    logic       clk = 0, rst = 1, ps2_clk = 1, ps2_data = 1, io_rdn = 1;
    logic [7:0] key_data;
    logic       ready, overflow, frame_err;

    ps2_key_fifo #(.FIFO_DEPTH(DEPTH), .FILTER_LEN(4), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data), .io_rdn(io_rdn),
        .key_data(key_data), .ready(ready), .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    int err_cnt = 0, wide = 0, exp_err = 0;
    logic fe_prev = 0;
    byte unsigned q[$];
    bit m_ovf = 0;
    logic       lat_rdy;
    logic [7:0] lat_kd;
    int         lat_err;

    always @(negedge clk) begin
        if (frame_err) begin
            err_cnt++;
            if (fe_prev) wide++;
        end
        fe_prev = frame_err;
    end

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_ready"}, 32'(ready), 32'(q.size() != 0));
        chk({tag, "_key"}, 32'(key_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
        chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        chk({tag, "_errs"}, err_cnt, exp_err);
    endtask

    task automatic bit_out(input logic b, input bit glitch);
        ps2_data = b;
        if (glitch) begin
            wait_n(4); ps2_clk = 0; wait_n(1); ps2_clk = 1; wait_n(5);
        end else wait_n(10);
        ps2_clk = 0;
        if (glitch) begin
            wait_n(8); ps2_clk = 1; wait_n(1); ps2_clk = 0; wait_n(11);
        end else begin
            wait_n(7);
            lat_rdy = ready; lat_kd = key_data; lat_err = err_cnt;
            wait_n(13);
        end
        ps2_clk = 1;
        wait_n(10);
    endtask

    task automatic send(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                        input bit glitch, input int nbits);
        logic [10:0] f;
        f = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) bit_out(f[i], glitch);
        ps2_data = 1;
        if (nbits == 11) begin
            if (bad_par || bad_stop) exp_err++;
            else if (q.size() < DEPTH) q.push_back(b);
            else m_ovf = 1;
        end
    endtask

    task automatic pop(input int hold);
        io_rdn = 0;
        #1 chk("read_head", 32'(key_data), q.size() != 0 ? 32'(q[0]) : 32'h0);
        wait_n(hold);
        io_rdn = 1;
        wait_n(2);
        if (q.size() != 0) begin
            void'(q.pop_front());
            m_ovf = 0;
        end
    endtask

    initial begin
        logic [7:0] b;
        int kind;
        wait_n(3);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_key", 32'(key_data), 0);
        chk("rst_ovf", 32'(overflow), 0);
        chk("rst_ferr", 32'(frame_err), 0);
        rst = 0;
        wait_n(5);

        send(8'h1C, 0, 0, 0, 11);
        chk("lat_ready", 32'(lat_rdy), 1);
        chk("lat_key", 32'(lat_kd), 32'h1C);
        chk("lat_err", lat_err, 0);
        check_state("f1c");
        pop(1);
        check_state("pop1");

        send(8'hF0, 0, 0, 0, 11);
        send(8'h1C, 0, 0, 0, 11);
        check_state("f0_1c");
        pop(1);
        check_state("after_f0");
        pop(1);
        check_state("after_1c");

        send(8'h1C, 1, 0, 0, 11);
        check_state("bad_par");
        send(8'h1D, 0, 0, 0, 11);
        check_state("f1d");
        pop(1);

        send(8'h00, 0, 0, 0, 5);
        wait_n(TMO + 10);
        exp_err++;
        check_state("timeout");
        send(8'h5A, 0, 0, 0, 11);
        check_state("f5a");
        pop(1);

        for (int i = 1; i <= 9; i++) send(8'(i), 0, 0, 0, 11);
        check_state("full");
        for (int i = 0; i < 8; i++) begin
            pop(1);
            check_state("drain");
        end

        send(8'hAA, 0, 0, 0, 11);
        send(8'hBB, 0, 0, 0, 11);
        pop(20);
        check_state("hold_pop");
        pop(1);
        pop(1);
        check_state("pop_empty");

        send(8'h33, 0, 0, 1, 11);
        check_state("glitch");
        pop(1);

        repeat (12) begin
            b = 8'($urandom);
            kind = $urandom_range(0, 5);
            send(b, kind == 0, kind == 1, 0, 11);
            repeat ($urandom_range(0, 2)) pop($urandom_range(1, 3));
            check_state("rand");
        end

        for (int i = 0; i < 9; i++) send(8'($urandom), 0, 0, 0, 11);
        check_state("refill");
        send(8'h77, 0, 0, 0, 4);
        rst = 1;
        #1;
        chk("midrst_ready", 32'(ready), 0);
        chk("midrst_key", 32'(key_data), 0);
        chk("midrst_ovf", 32'(overflow), 0);
        chk("midrst_ferr", 32'(frame_err), 0);
        q.delete();
        m_ovf = 0;
        wait_n(3);
        rst = 0;
        wait_n(5);
        send(8'h42, 0, 0, 0, 11);
        check_state("post_rst");

        chk("err_pulse_width", wide, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
